irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt sequencer for the 5-stage pipelined CPU; drives the Control IRQ input.
//  Synchronises and latches peripheral interrupt requests, then waits for a safe ID-stage slot.
//  Takes the interrupt there: flushes IF/ID and saves the EPC.
//  Blocks nesting while the handler runs; releases on ERET.
// PARAMETERS
//  NUM_SRC      4   number of interrupt sources (1..8)
//  SYNC_STAGES  2   synchroniser flops per source (>=2)
// PORTS
//  clk          in   1        CPU clock (single clock domain)
//  reset        in   1        asynchronous, active-high reset
//  irq_in       in   NUM_SRC  raw peripheral requests, rising-edge significant, asynchronous
//  irq_en       in   NUM_SRC  per-source enable mask
//  pc_id        in   32       PC of the instruction currently in ID
//  id_valid     in   1        ID holds a real instruction (not a bubble or flushed)
//  id_is_branch in   1        ID instruction is a branch/jump/jr
//  stall        in   1        hazard unit is stalling IF/ID this cycle
//  kernel_mode  in   1        PC[31] of the ID instruction (1 = supervisor)
//  eret_id      in   1        ERET decoded in ID
//  irq_take     out  1        1-cycle pulse; Control selects PCSrc=3'b100 this cycle
//  flush_id     out  1        flush IF/ID; equals irq_take
//  epc          out  32       saved return PC
//  irq_cause    out  3        index of the taken source
//  busy         out  1        handler active (state HANDLER)
//  pending      out  NUM_SRC  latched pending bits (visible to software)
// BEHAVIOUR
//  Reset (async, any state): all sync flops, pending, epc, irq_cause = 0; state=IDLE; outputs 0.
//  Sync: irq_in -> SYNC_STAGES flops -> s; rise = s & ~s_d (s_d = s delayed 1 cycle).
//  Pending: per bit, pending <= (pending & ~clr) | rise.
//   - clr is one-hot on the taken source during the take cycle.
//   - A rise on the same bit in that cycle wins: the bit stays set.
//   - Disabled sources still latch, but cannot request.
//  req = |(pending & irq_en); sel = lowest set index of (pending & irq_en).
//  FSM states IDLE, ARM, HANDLER:
//   IDLE:    req & ~kernel_mode -> ARM.
//   ARM:     ok = id_valid & ~id_is_branch & ~stall & ~kernel_mode.
//            irq_take is combinational: irq_take = (state==ARM) & ok & req.
//            On irq_take: epc <= pc_id; irq_cause <= sel; clear pending[sel]; -> HANDLER.
//            ~req (masked or cleared) -> IDLE, no take.
//            ok=0 -> remain in ARM.
//   HANDLER: busy=1; irq_take is never asserted; new rises keep latching.
//            eret_id & ~stall -> IDLE.
//            If req is still set, ARM on the next cycle: minimum 1 free cycle between handlers.
//  Branch in ID: the interrupt is deferred until ID holds a non-branch instruction.
//  The branch target is never lost.
//  Latency, SYNC_STAGES=2, all conditions true: irq_in rises before edge 1.
//   -> edge 3: pending set; edge 4: ARM; irq_take high in the cycle after edge 4.
//   -> epc/cause valid after edge 5.
//  epc and irq_cause hold until the next take; busy falls the cycle after ERET is accepted.
//  Reset mid-handler: returns to IDLE; pending is lost.
//  irq_in pulses shorter than 1 clk may be missed; a level held high gives exactly one request.
// TESTING
//  1. irq_in[2] rises, en=4'hF, pc_id=0x40, all ok -> irq_take 1 cycle at cycle 4; epc=0x40, cause=2, busy=1.
//  2. irq_in[0] and irq_in[3] rise together -> cause=0 first; after ERET, second take with cause=3, pending=4'b0000.
//  3. Request arrives while id_is_branch=1 for 3 cycles -> irq_take delayed until id_is_branch=0; epc = that PC.
//  4. In HANDLER, irq_in[1] rises -> no take while busy; ERET -> IDLE; take 2 cycles later with cause=1.
//  5. ARM with en cleared to 0 -> back to IDLE, no take; pending bit retained; re-enable -> take.
//  6. reset asserted in HANDLER/ARM -> outputs and pending 0 immediately, before any clock edge.

Source files
------------

// File: rtl/irq_sequencer_if.sv
// Signal bundle between the CPU pipeline/peripherals and the interrupt sequencer.
// The CPU side is the master and the sequencer is the slave.
interface irq_sequencer_if #(
  parameter int NUM_SRC = 4
);
  // Peripheral side
  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_en;
  logic [NUM_SRC-1:0] pending;

  // Pipeline side (ID stage view)
  logic [31:0]        pc_id;
  logic               id_valid;
  logic               id_is_branch;
  logic               stall;
  logic               kernel_mode;
  logic               eret_id;

  // Take handshake: irq_take is a single-cycle strobe with no back-pressure.
  // Control must redirect the PC in that same cycle; flush_id mirrors it.
  logic               irq_take;
  logic               flush_id;
  logic [31:0]        epc;
  logic [2:0]         irq_cause;
  logic               busy;

  // Sequencer FSM state, exposed for debug and checkers
  logic [1:0]         state_dbg;

  modport master (
    output irq_in, irq_en, pc_id, id_valid, id_is_branch, stall, kernel_mode, eret_id,
    input  pending, irq_take, flush_id, epc, irq_cause, busy, state_dbg
  );

  modport slave (
    input  irq_in, irq_en, pc_id, id_valid, id_is_branch, stall, kernel_mode, eret_id,
    output pending, irq_take, flush_id, epc, irq_cause, busy, state_dbg
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: synchronises and latches peripheral requests, waits for a safe
// non-branch ID slot, then takes the interrupt (flush IF/ID, save EPC) and blocks nesting until ERET.
module irq_sequencer #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  irq_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr;
  logic [2:0]         sel;
  logic               req;
  logic               ok;
  logic               take;
  logic [31:0]        epc_q;
  logic [2:0]         cause_q;

  // Synchroniser chain plus one extra flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  assign active = pending_q & bus.irq_en;
  assign req    = |active;

  // Descending scan so the lowest active index is the one left in sel
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = 3'(i);
    end
  end

  assign ok   = bus.id_valid & ~bus.id_is_branch & ~bus.stall & ~bus.kernel_mode;
  assign take = (state_q == ARM) & ok & req;

  always_comb begin
    clr = '0;
    if (take) clr = NUM_SRC'(1) << sel;
  end

  // A rise arriving in the take cycle re-sets the bit being cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q   <= '0;
      cause_q <= '0;
    end else if (take) begin
      epc_q   <= bus.pc_id;
      cause_q <= sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !bus.kernel_mode) state_d = ARM;
      end
      ARM: begin
        if (!req)    state_d = IDLE;
        else if (ok) state_d = HANDLER;
      end
      HANDLER: begin
        // Returning through IDLE guarantees one free cycle between handlers
        if (bus.eret_id && !bus.stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.irq_take  = take;
  assign bus.flush_id  = take;
  assign bus.epc       = epc_q;
  assign bus.irq_cause = cause_q;
  assign bus.busy      = (state_q == HANDLER);
  assign bus.pending   = pending_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios plus a randomized phase, all checked
// against a behavioural model of the sequencing rules.
module tb_irq_sequencer;

  localparam int NS = 4;
  localparam int SS = 2;

  logic clk;
  logic reset;

  irq_sequencer_if #(.NUM_SRC(NS)) bus ();

  irq_sequencer #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  logic [NS-1:0] seen[$];     // irq_in as sampled at each edge since reset
  logic [NS-1:0] m_pending;
  bit            m_waiting;   // request seen, looking for a safe slot
  bit            m_in_handler;
  logic [31:0]   m_epc;
  logic [2:0]    m_cause;
  bit            last_take;
  int            edges;
  int            take_edge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    seen.delete();
    for (int i = 0; i <= SS; i++) seen.push_back('0);
    m_pending    = '0;
    m_waiting    = 0;
    m_in_handler = 0;
    m_epc        = '0;
    m_cause      = '0;
    edges        = 0;
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven
  task automatic cycle();
    logic [NS-1:0] act;
    logic [NS-1:0] s_now;
    logic [NS-1:0] s_old;
    logic [NS-1:0] rise;
    bit            ok;
    bit            want;
    bit            m_take;
    #1;
    act    = m_pending & bus.irq_en;
    want   = (act != '0);
    ok     = bus.id_valid && !bus.id_is_branch && !bus.stall && !bus.kernel_mode;
    m_take = m_waiting && ok && want;
    chk("irq_take", bus.irq_take, m_take);
    chk("flush_id", bus.flush_id, m_take);
    last_take = bus.irq_take;
    if (bus.irq_take && take_edge < 0) take_edge = edges;
    @(posedge clk);
    s_now = seen[seen.size() - SS];
    s_old = seen[seen.size() - SS - 1];
    rise  = s_now & ~s_old;
    if (m_take) begin
      m_pending[lowest(act)] = 1'b0;
      m_epc   = bus.pc_id;
      m_cause = lowest(act);
    end
    m_pending = m_pending | rise;
    if (m_in_handler) begin
      if (bus.eret_id && !bus.stall) m_in_handler = 0;
    end else if (m_waiting) begin
      if (!want) m_waiting = 0;
      else if (ok) begin
        m_waiting    = 0;
        m_in_handler = 1;
      end
    end else if (want && !bus.kernel_mode) begin
      m_waiting = 1;
    end
    seen.push_back(bus.irq_in);
    if (seen.size() > 8) void'(seen.pop_front());
    edges++;
    @(negedge clk);
    chk("epc", bus.epc, m_epc);
    chk("irq_cause", 32'(bus.irq_cause), 32'(m_cause));
    chk("busy", 32'(bus.busy), 32'(m_in_handler));
    chk("pending", 32'(bus.pending), 32'(m_pending));
  endtask

  task automatic run_until_take(input string tag, input int max_cycles);
    last_take = 0;
    for (int i = 0; i < max_cycles && !last_take; i++) cycle();
    chk(tag, 32'(last_take), 32'd1);
  endtask

  task automatic eret_once();
    bus.eret_id = 1'b1;
    cycle();
    bus.eret_id = 1'b0;
  endtask

  // Entered at a negedge; asserts reset mid-cycle and checks outputs before any edge
  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_take"}, 32'(bus.irq_take), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
    chk({tag, "_epc"}, bus.epc, 32'd0);
    chk({tag, "_cause"}, 32'(bus.irq_cause), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.irq_in = '0;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int takes;
    reset            = 1'b1;
    bus.irq_in       = '0;
    bus.irq_en       = 4'hF;
    bus.pc_id        = 32'h40;
    bus.id_valid     = 1'b1;
    bus.id_is_branch = 1'b0;
    bus.stall        = 1'b0;
    bus.kernel_mode  = 1'b0;
    bus.eret_id      = 1'b0;
    take_edge        = -1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_take", 32'(bus.irq_take), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    chk("reset_epc", bus.epc, 32'd0);
    reset = 1'b0;
    model_reset();

    // 1: single source, all conditions true, fixed latency
    bus.irq_in = 4'b0100;
    take_edge  = -1;
    repeat (8) cycle();
    chk("t1_take_edge", 32'(take_edge), 32'd4);
    chk("t1_epc", bus.epc, 32'h40);
    chk("t1_cause", 32'(bus.irq_cause), 32'd2);
    chk("t1_busy", 32'(bus.busy), 32'd1);

    // 2: simultaneous rises, lowest index first
    bus.irq_in = '0;
    eret_once();
    bus.irq_in = 4'b1001;
    run_until_take("t2_take0", 20);
    chk("t2_cause0", 32'(bus.irq_cause), 32'd0);
    chk("t2_pend0", 32'(bus.pending), 32'b1000);
    eret_once();
    run_until_take("t2_take3", 20);
    chk("t2_cause3", 32'(bus.irq_cause), 32'd3);
    chk("t2_pend3", 32'(bus.pending), 32'b0000);

    // 3: branch in ID defers the take
    bus.irq_in = '0;
    eret_once();
    bus.id_is_branch = 1'b1;
    bus.pc_id        = 32'h80;
    bus.irq_in       = 4'b0010;
    takes = 0;
    repeat (7) begin
      cycle();
      takes += int'(last_take);
    end
    chk("t3_no_take_on_branch", 32'(takes), 32'd0);
    bus.id_is_branch = 1'b0;
    bus.pc_id        = 32'h100;
    run_until_take("t3_take", 4);
    chk("t3_epc", bus.epc, 32'h100);
    chk("t3_cause", 32'(bus.irq_cause), 32'd1);

    // 4: request during handler waits for ERET plus one free cycle
    bus.irq_in = '0;
    repeat (2) cycle();
    bus.irq_in = 4'b0010;
    takes = 0;
    repeat (6) begin
      cycle();
      takes += int'(last_take);
    end
    chk("t4_no_nest", 32'(takes), 32'd0);
    chk("t4_pending", 32'(bus.pending), 32'b0010);
    eret_once();
    chk("t4_busy_after_eret", 32'(bus.busy), 32'd0);
    cycle();
    chk("t4_gap_cycle", 32'(last_take), 32'd0);
    cycle();
    chk("t4_take", 32'(last_take), 32'd1);
    chk("t4_cause", 32'(bus.irq_cause), 32'd1);

    // 5: mask while armed drops back, bit retained, re-enable takes
    eret_once();
    bus.irq_in   = '0;
    bus.id_valid = 1'b0;
    repeat (2) cycle();
    bus.irq_in = 4'b0001;
    repeat (5) cycle();
    chk("t5_armed", 32'(m_waiting), 32'd1);
    bus.irq_en = '0;
    cycle();
    chk("t5_masked_take", 32'(last_take), 32'd0);
    chk("t5_masked_pending", 32'(bus.pending), 32'b0001);
    chk("t5_masked_busy", 32'(bus.busy), 32'd0);
    repeat (2) cycle();
    bus.irq_en   = 4'hF;
    bus.id_valid = 1'b1;
    bus.pc_id    = 32'h200;
    run_until_take("t5_take", 6);
    chk("t5_cause", 32'(bus.irq_cause), 32'd0);
    chk("t5_epc", bus.epc, 32'h200);

    // 6: reset in HANDLER with a pending bit, then reset while a take is in flight
    bus.irq_in = 4'b0101;
    repeat (4) cycle();
    chk("t6_pending_pre", 32'(bus.pending), 32'b0100);
    async_reset_check("t6_handler");
    repeat (2) cycle();
    bus.irq_in = 4'b1000;
    repeat (4) cycle();
    #1;
    chk("t6_take_pre", 32'(bus.irq_take), 32'd1);
    #1;
    async_reset_check("t6_arm");

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.irq_in = bus.irq_in ^ (NS'(1) << $urandom_range(0, NS - 1));
      bus.irq_en       = ($urandom_range(0, 9) == 0) ? NS'($urandom) : 4'hF;
      bus.id_valid     = ($urandom_range(0, 9) < 8);
      bus.id_is_branch = ($urandom_range(0, 9) < 2);
      bus.stall        = ($urandom_range(0, 9) < 2);
      bus.kernel_mode  = ($urandom_range(0, 9) == 0);
      bus.eret_id      = ($urandom_range(0, 9) == 0);
      bus.pc_id        = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
